// File: rtl/serial_arith_unit8.sv
// serial_arith_unit8: bit-serial 4-op arithmetic unit, one full-adder slice, LSB first
// Ports: clk/rst (sync, active-high); start/sel1/sel0/cin/x/y latched in IDLE;
// busy high while shifting, done pulses when f/cout update; f/cout hold until next completion.
module serial_arith_unit8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel1,
  input  logic             sel0,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, r_q, r_d, f_q, f_d;
  logic [1:0] sel_q, sel_d;
  logic cin_q, cin_d, c_q, c_d, cout_q, cout_d;
  logic b, s, co;
  assign b = (sel_q == 2'b00) ? 1'b0 : (sel_q == 2'b01) ? y_q[0] : (sel_q == 2'b10) ? ~y_q[0] : 1'b1;
  // transfer mode outputs y while the carry chain keeps running x + all-ones
  assign s = (&sel_q && cin_q) ? y_q[0] : x_q[0] ^ b ^ c_q;
  assign co = (x_q[0] & b) | (x_q[0] & c_q) | (b & c_q);
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign f = f_q;
  assign cout = cout_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    r_d = r_q;
    f_d = f_q;
    sel_d = sel_q;
    cin_d = cin_q;
    c_d = c_q;
    cout_d = cout_q;
    if (state_q == IDLE && start) begin
      state_d = SHIFT;
      cnt_d = CW'(WIDTH - 1);
      x_d = x;
      y_d = y;
      r_d = '0;
      sel_d = {sel1, sel0};
      cin_d = cin;
      c_d = sel1 ? (~sel0 & ~cin) : cin;
    end else if (state_q == SHIFT) begin
      x_d = x_q >> 1;
      y_d = y_q >> 1;
      r_d = {s, r_q[WIDTH-1:1]};
      c_d = co;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_d = DONE;
        f_d = {s, r_q[WIDTH-1:1]};
        cout_d = co;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      r_q <= '0;
      f_q <= '0;
      sel_q <= '0;
      cin_q <= 1'b0;
      c_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      r_q <= r_d;
      f_q <= f_d;
      sel_q <= sel_d;
      cin_q <= cin_d;
      c_q <= c_d;
      cout_q <= cout_d;
    end
  end
endmodule

// File: tb/tb_serial_arith_unit8.sv
// tb_serial_arith_unit8: randomized and directed self-checking bench for serial_arith_unit8
module tb_serial_arith_unit8;
  logic clk = 1'b0, rst, start, sel1, sel0, cin, busy, done, cout;
  logic [7:0] x, y, f;
  int errors = 0, checks = 0;
  serial_arith_unit8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sel1(sel1), .sel0(sel0), .cin(cin),
    .x(x), .y(y), .busy(busy), .done(done), .f(f), .cout(cout)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] model(input logic [2:0] s, input int xx, input int yy);
    int t;
    case (s[2:1])
      2'd0: t = xx + s[0];
      2'd1: t = xx + yy + s[0];
      2'd2: t = xx - yy - s[0] + 256;
      default: return {xx != 0, s[0] ? 8'(yy) : 8'(xx - 1)};
    endcase
    return 9'(t);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] s, input logic [7:0] xx, input logic [7:0] yy);
    {sel1, sel0, cin} = s;
    x = xx;
    y = yy;
  endtask
  task automatic run_op(input logic [2:0] s, input logic [7:0] xx, input logic [7:0] yy,
                        output logic [7:0] rf, output logic rc, output int lat);
    drive(s, xx, yy);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    rf = f;
    rc = cout;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    drive(3'b000, 8'd0, 8'd0);
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (f !== 8'd0) begin errors++; $display("FAIL reset_f got %0d exp 0", f); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_sweep();
    logic [7:0] rf;
    logic rc;
    int lat;
    logic [8:0] exp_tab [8] = '{9'd32, 9'd33, 9'd48, 9'd49, 9'h110, 9'h10f, 9'h11f, 9'h110};
    for (int i = 0; i < 8; i++) begin
      run_op(3'(i), 8'd32, 8'd16, rf, rc, lat);
      checks++; if ({rc, rf} !== exp_tab[i]) begin errors++; $display("FAIL sweep_%0d got %0d/%0d exp %0d/%0d", i, rf, rc, exp_tab[i][7:0], exp_tab[i][8]); end
      checks++; if ({rc, rf} !== model(3'(i), 32, 16)) begin errors++; $display("FAIL sweep_model_%0d got %h exp %h", i, {rc, rf}, model(3'(i), 32, 16)); end
      checks++; if (lat != 9) begin errors++; $display("FAIL sweep_latency_%0d got %0d exp 9", i, lat); end
      tick();
    end
  endtask
  task automatic test_boundary();
    logic [7:0] rf;
    logic rc;
    int lat;
    run_op(3'b010, 8'd200, 8'd100, rf, rc, lat);
    checks++; if ({rc, rf} !== {1'b1, 8'd44}) begin errors++; $display("FAIL bnd_add_ovf got %0d/%0d exp 44/1", rf, rc); end
    tick();
    run_op(3'b001, 8'd255, 8'd77, rf, rc, lat);
    checks++; if ({rc, rf} !== {1'b1, 8'd0}) begin errors++; $display("FAIL bnd_inc_wrap got %0d/%0d exp 0/1", rf, rc); end
    tick();
    run_op(3'b110, 8'd0, 8'd33, rf, rc, lat);
    checks++; if ({rc, rf} !== {1'b0, 8'd255}) begin errors++; $display("FAIL bnd_dec_zero got %0d/%0d exp 255/0", rf, rc); end
    tick();
    run_op(3'b100, 8'd5, 8'd9, rf, rc, lat);
    checks++; if ({rc, rf} !== {1'b0, 8'd252}) begin errors++; $display("FAIL bnd_sub_borrow got %0d/%0d exp 252/0", rf, rc); end
    tick();
  endtask
  task automatic test_handshake();
    int nbusy = 0, ndone = 0;
    logic [8:0] e = model(3'b010, 100, 27);
    logic [8:0] got = 9'h1ff;
    drive(3'b010, 8'd100, 8'd27);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      nbusy += int'(busy);
      ndone += int'(done);
      if (done) got = {cout, f};
      if (i == 3) begin
        drive(3'b100, 8'd3, 8'd200);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    checks++; if (got !== e) begin errors++; $display("FAIL hs_result got %h exp %h", got, e); end
    checks++; if (nbusy != 8) begin errors++; $display("FAIL hs_busy_cycles got %0d exp 8", nbusy); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL hs_done_cycles got %0d exp 1", ndone); end
  endtask
  task automatic test_stability();
    logic [7:0] rf;
    logic rc;
    int lat;
    logic [8:0] prev, e;
    int n = 0;
    run_op(3'b011, 8'd77, 8'd88, rf, rc, lat);
    prev = model(3'b011, 77, 88);
    tick();
    e = model(3'b101, 150, 51);
    drive(3'b101, 8'd150, 8'd51);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && n < 30) begin
      checks++; if ({cout, f} !== prev) begin errors++; $display("FAIL stab_hold_%0d got %h exp %h", n, {cout, f}, prev); end
      drive(3'($urandom), 8'($urandom), 8'($urandom));
      start = n[0];
      tick();
      n++;
    end
    start = 1'b0;
    checks++; if ({cout, f} !== e || !done) begin errors++; $display("FAIL stab_result got %h done %b exp %h", {cout, f}, done, e); end
    tick();
  endtask
  task automatic test_reset_mid();
    logic [7:0] rf;
    logic rc;
    int lat, nd = 0;
    drive(3'b010, 8'd120, 8'd7);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy, done, cout, f} !== 11'd0) begin errors++; $display("FAIL midrst_state got busy %b done %b f %0d cout %b exp all 0", busy, done, f, cout); end
    for (int i = 0; i < 12; i++) begin
      nd += int'(done);
      tick();
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", nd); end
    run_op(3'b010, 8'd120, 8'd7, rf, rc, lat);
    checks++; if ({rc, rf} !== model(3'b010, 120, 7) || lat != 9) begin errors++; $display("FAIL midrst_recover got %h lat %0d exp %h lat 9", {rc, rf}, lat, model(3'b010, 120, 7)); end
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b exp 0", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_idle got %b exp 0", busy); end
  endtask
  task automatic test_back_to_back();
    logic [2:0] s;
    logic [7:0] xx, yy;
    logic [8:0] e;
    int gap;
    s = 3'($urandom);
    xx = 8'($urandom);
    yy = 8'($urandom);
    e = model(s, xx, yy);
    drive(s, xx, yy);
    start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!done && gap < 40);
      checks++; if ({cout, f} !== e || !done) begin errors++; $display("FAIL b2b_%0d got %h done %b exp %h (s=%b x=%0d y=%0d)", n, {cout, f}, done, e, s, xx, yy); end
      if (n > 0) begin
        checks++; if (gap != 10) begin errors++; $display("FAIL b2b_gap_%0d got %0d exp 10", n, gap); end
      end
      s = 3'($urandom);
      xx = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 1) * 255) : 8'($urandom);
      yy = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 1) * 255) : 8'($urandom);
      e = model(s, xx, yy);
      drive(s, xx, yy);
    end
    start = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    test_reset();
    test_sweep();
    test_boundary();
    test_handshake();
    test_stability();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
